exec_trace_monitor: RTL

Synthesizable execution monitor attached beside the single-cycle RISC-V core. It snoops architectural commit signals (PC, instruction, register-file write, data-memory write), counts cycles while a run is active, detects end-of-program (repeated halt instruction) and watchdog timeout, and buffers commit records in a parametrised first-word-fall-through trace FIFO. The FIFO is drained by a debug port or a bench. It replaces ad-hoc hierarchical peeking with an on-chip, self-checking trace source.

---
 rtl/exec_trace_monitor_if.sv | 21 ++
 rtl/exec_trace_monitor.sv | 117 +++++++++++
 2 files changed

// File: rtl/exec_trace_monitor_if.sv
// Trace FIFO read port of the execution monitor: FWFT head record plus consumer ready.
interface exec_trace_monitor_if #(
    parameter int XLEN = 32
);
    logic            trace_valid;
    logic            trace_ready;
    logic [XLEN-1:0] trace_pc;
    logic            trace_kind;
    logic [XLEN-1:0] trace_addr;
    logic [XLEN-1:0] trace_data;

    modport master (
        output trace_valid, trace_pc, trace_kind, trace_addr, trace_data,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_pc, trace_kind, trace_addr, trace_data,
        output trace_ready
    );
endinterface

// File: rtl/exec_trace_monitor.sv
// Execution monitor beside the single-cycle core: run/halt/timeout FSM, cycle and
// drop counters, and a first-word-fall-through trace FIFO of commit records.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RUN     | counting cycles and capturing commit records
// HALTED  | halt marker seen HALT_REPEAT consecutive cycles
// TIMEOUT | cycle_count reached TIMEOUT_CYCLES without halt
module exec_trace_monitor #(
    parameter int          XLEN           = 32,
    parameter int          TRACE_DEPTH    = 16,
    parameter logic [31:0] HALT_INSTR     = 32'h00000013,
    parameter int          HALT_REPEAT    = 3,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XLEN-1:0]      pc,
    input  logic [31:0]          instr,
    input  logic                 rd_we,
    input  logic [4:0]           rd_addr,
    input  logic [XLEN-1:0]      rd_data,
    input  logic                 dm_we,
    input  logic [XLEN-1:0]      dm_addr,
    input  logic [XLEN-1:0]      dm_wdata,
    exec_trace_monitor_if.master trace,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 overflow
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int HW = $clog2(HALT_REPEAT + 1);
    localparam int RW = 3 * XLEN + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    logic [RW-1:0]    mem [TRACE_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [HW-1:0]    halt_cnt, halt_next;
    logic [CNT_W-1:0] cycle_next, drop_next;
    logic [CNT_W:0]   drop_sum;
    logic [1:0]       drop_inc;
    logic [RW-1:0]    rec, head;
    logic             running, empty, full, pop, has_reg, has_rec, push, fifo_drop, collide;

    // start overrides capture: a restart cycle only clears and flushes
    assign running   = (state == S_RUN) && !start;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && trace.trace_ready;
    assign has_reg   = rd_we && (rd_addr != 5'd0);
    assign has_rec   = running && (has_reg || dm_we);
    assign push      = has_rec && (!full || pop);
    assign fifo_drop = has_rec && !push;
    assign collide   = running && has_reg && dm_we;

    assign drop_inc   = {1'b0, fifo_drop} + {1'b0, collide};
    assign drop_sum   = {1'b0, drop_count} + (CNT_W + 1)'(drop_inc);
    assign drop_next  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    assign cycle_next = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    assign halt_next  = (instr == HALT_INSTR) ? halt_cnt + HW'(1) : '0;

    assign rec = has_reg ? {pc, 1'b0, XLEN'(rd_addr), rd_data}
                         : {pc, 1'b1, dm_addr, dm_wdata};

    assign head              = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign trace.trace_valid = !empty;
    assign {trace.trace_pc, trace.trace_kind, trace.trace_addr, trace.trace_data} = head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cycle_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            halt_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (start) begin
            state       <= S_RUN;
            cycle_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            halt_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            if (state == S_RUN) begin
                cycle_count <= cycle_next;
                halt_cnt    <= halt_next;
                drop_count  <= drop_next;
                if (fifo_drop || collide)
                    overflow <= 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + (AW + 1)'(1);
                // halt takes priority when both fire on the same cycle
                if (halt_next == HW'(HALT_REPEAT))
                    state <= S_HALTED;
                else if (cycle_next == CNT_W'(TIMEOUT_CYCLES))
                    state <= S_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= rec;
    end
endmodule
